cache_refill: RTL and testbench
===============================

# cache_refill

Miss-handling controller for the direct-mapped instruction/data cache: 32 lines, 22-bit tag, 5-bit line index, 32-byte lines. It is the write side of the tag store. When the combinational tag lookup flags a miss on a CPU access, this block does three things:
- stalls the CPU;
- fetches the 8-word line from memory, one word per handshake;
- writes each word into the data array, then writes the new tag and sets the line's valid bit.

It sits between the tag/data arrays and the memory bus.

## Interface
Parameters:
- TAG_W, 22, tag width (addr[31:10])
- IDX_W, 5, line index width (addr[9:5])
- WORD_W, 3, word-in-line index width (addr[4:2]); the line is 2**WORD_W = 8 words

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  asynchronous, active-high reset
- cpu_req  in  1  CPU access valid this cycle
- addr  in  32  CPU byte address
- miss_in  in  1  miss flag from the tag lookup for addr
- stall  out  1  CPU must hold its access
- mem_req  out  1  memory read request
- mem_addr  out  32  word-aligned read address
- mem_ack  in  1  memory returns mem_rdata this cycle
- mem_rdata  in  32  read data
- data_we  out  1  data-array write strobe
- data_idx  out  5  data-array line index
- data_word  out  3  data-array word index
- data_wdata  out  32  data-array write data
- tag_we  out  1  tag-store write strobe
- tag_idx  out  5  tag-store line index
- tag_wdata  out  22  tag-store write data
- valid_set  out  1  set the valid bit of line tag_idx (asserted together with tag_we)

## Operation
- States: IDLE, FETCH, COMMIT, DONE.
- IDLE:
  - cpu_req & miss_in latches r_tag=addr[31:10] and r_idx=addr[9:5], clears word counter wc=0, and moves to FETCH.
  - miss_in without cpu_req is ignored.
- FETCH:
  - Outputs: mem_req=1; mem_addr={r_tag, r_idx, wc, 2'b00}.
  - On mem_ack: data_we=1, data_idx=r_idx, data_word=wc, data_wdata=mem_rdata (combinational from mem_ack, same cycle); then wc increments.
  - mem_ack on wc==7 moves to COMMIT.
  - Without mem_ack, state, wc and mem_addr hold.
- COMMIT: one cycle of tag_we=1, valid_set=1, tag_idx=r_idx, tag_wdata=r_tag; then DONE.
- DONE: one cycle with stall=0 and miss_in ignored, so the lookup settles on the new tag; then IDLE.
- stall is asserted:
  - in IDLE when cpu_req & miss_in (combinational);
  - in all of FETCH and COMMIT.
- Words are fetched in ascending order 0..7; there is no critical-word-first.
- Changes on addr, cpu_req or miss_in outside IDLE are ignored; the refill always completes on the latched line.
- mem_ack outside FETCH is ignored and causes no writes.
- wc is 3 bits; the increment after word 7 wraps to 0, and that value is unused.

## Timing
- Reset values: stall=0, mem_req=0, mem_addr=0, data_we=0, tag_we=0, valid_set=0, all index/data outputs 0; state IDLE, wc=0.
- Reset mid-refill returns to IDLE immediately:
  - no tag_we and no valid_set are issued;
  - data words already written remain, but the line stays invalid/old-tagged.
- With mem_ack tied high, a miss detected at cycle 0 gives:
  - FETCH in cycles 1-8 (one word per cycle);
  - COMMIT in cycle 9;
  - DONE in cycle 10 (stall low);
  - IDLE in cycle 11.
- General miss penalty: 3 + sum of per-word ack latencies (each ≥1).
- A miss arriving in DONE is not accepted; it is accepted in the next IDLE cycle.
- mem_addr changes only on the clock edge after an acked beat, or on entry to FETCH.

## Structure
- Shared package cache_pkg holds:
  - TAG_W, IDX_W, WORD_W and LINE_WORDS=8;
  - address field slicing constants (TAG_LSB=10, IDX_LSB=5, WORD_LSB=2);
  - the refill state enum {IDLE, FETCH, COMMIT, DONE}.
- The tag lookup and the data array reuse cache_pkg.
- No sub-module: the FSM, word counter and address latch are one block.

## Test plan
- Reset, then a miss on addr 0xFFFFFC20 with mem_ack tied 1 -> mem_addr 0xFFFFFC20..0xFFFFFC3C over cycles 1-8, data_word 0..7; tag_we/valid_set in cycle 9 with tag_idx=1, tag_wdata=0x3FFFFF; stall low at cycle 10.
- mem_ack delayed 3 cycles per word -> mem_addr and wc hold while waiting, no data_we without ack, total stall 8×3+2 cycles.
- addr changed to 0x00000000 during FETCH -> remaining mem_addr values still on the latched line, tag_wdata unchanged.
- rst asserted after word 4 -> next cycle all outputs zero, no tag_we ever issued; a new miss restarts from word 0.
- mem_ack pulses in IDLE/COMMIT/DONE -> no data_we; cpu_req & miss_in during DONE -> accepted only on the following IDLE cycle.
- cpu_req=0 with miss_in=1 -> stall stays 0, no mem_req.

Source files
------------

// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared cache geometry, address slicing constants and refill state type
//
// Shared by the refill controller, the tag lookup and the data array.
// Geometry: 32 direct-mapped lines, 22-bit tag, 32-byte (8-word) lines.
package cache_pkg;

    // Field widths of a CPU byte address: {tag, index, word, byte}
    localparam int TAG_W      = 22;
    localparam int IDX_W      = 5;
    localparam int WORD_W     = 3;
    localparam int LINE_WORDS = 1 << WORD_W;

    // Bit positions of the address fields
    localparam int WORD_LSB = 2;
    localparam int IDX_LSB  = WORD_LSB + WORD_W;
    localparam int TAG_LSB  = IDX_LSB + IDX_W;

    // Refill controller states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        COMMIT = 2'd2,
        DONE   = 2'd3
    } refill_state_t;

endpackage

// File: rtl/cache_refill.sv
// rtl/cache_refill.sv - miss-handling refill controller, write side of the tag store
//
// On a CPU miss, stalls the CPU, reads the 8-word line from memory one word per
// handshake (ascending order), writes each word into the data array, then writes
// the tag and sets the line's valid bit.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   cpu_req, addr, miss_in   CPU access and tag-lookup miss flag
//   stall                    CPU hold
//   mem_req, mem_addr        memory read request / word-aligned address
//   mem_ack, mem_rdata       memory read return
//   data_we/idx/word/wdata   data-array write port
//   tag_we/idx/wdata         tag-store write port
//   valid_set                set valid bit of line tag_idx (with tag_we)
module cache_refill #(
    parameter int TAG_W  = cache_pkg::TAG_W,
    parameter int IDX_W  = cache_pkg::IDX_W,
    parameter int WORD_W = cache_pkg::WORD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic [31:0]       addr,
    input  logic              miss_in,
    output logic              stall,
    output logic              mem_req,
    output logic [31:0]       mem_addr,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              data_we,
    output logic [IDX_W-1:0]  data_idx,
    output logic [WORD_W-1:0] data_word,
    output logic [31:0]       data_wdata,
    output logic              tag_we,
    output logic [IDX_W-1:0]  tag_idx,
    output logic [TAG_W-1:0]  tag_wdata,
    output logic              valid_set
);

    import cache_pkg::*;

    localparam int IDX_BASE = WORD_LSB + WORD_W;
    localparam int TAG_BASE = IDX_BASE + IDX_W;

    refill_state_t     state;
    logic [TAG_W-1:0]  r_tag;
    logic [IDX_W-1:0]  r_idx;
    logic [WORD_W-1:0] wc;
    logic [WORD_W-1:0] wc_next;
    logic              miss_start;
    logic              beat;
    logic              last_word;

    // Word and byte offsets never select anything here: the refill always
    // covers the whole line starting at word 0.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr[IDX_BASE-1:0];

    assign miss_start = (state == IDLE) && cpu_req && miss_in;
    assign beat       = (state == FETCH) && mem_ack;
    assign wc_next    = wc + 1'b1;
    assign last_word  = &wc;

    // Stall rises combinationally on the miss so the CPU holds its access in
    // the very cycle the lookup flags it; DONE releases it so the lookup can
    // re-evaluate against the freshly written tag.
    assign stall = miss_start || (state == FETCH) || (state == COMMIT);

    // Data-array writes follow mem_ack in the same cycle; the port is
    // driven to zero when not writing.
    assign data_we    = beat;
    assign data_idx   = beat ? r_idx : '0;
    assign data_word  = beat ? wc : '0;
    assign data_wdata = beat ? mem_rdata : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            r_tag     <= '0;
            r_idx     <= '0;
            wc        <= '0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            tag_we    <= 1'b0;
            valid_set <= 1'b0;
            tag_idx   <= '0;
            tag_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_req && miss_in) begin
                        r_tag    <= addr[TAG_BASE +: TAG_W];
                        r_idx    <= addr[IDX_BASE +: IDX_W];
                        wc       <= '0;
                        mem_req  <= 1'b1;
                        mem_addr <= {addr[TAG_BASE +: TAG_W], addr[IDX_BASE +: IDX_W],
                                     {WORD_W{1'b0}}, 2'b00};
                        state    <= FETCH;
                    end
                end

                FETCH: begin
                    // Address and counter only move after an acknowledged beat.
                    if (mem_ack) begin
                        wc <= wc_next;
                        if (last_word) begin
                            mem_req   <= 1'b0;
                            mem_addr  <= '0;
                            tag_we    <= 1'b1;
                            valid_set <= 1'b1;
                            tag_idx   <= r_idx;
                            tag_wdata <= r_tag;
                            state     <= COMMIT;
                        end else begin
                            mem_addr <= {r_tag, r_idx, wc_next, 2'b00};
                        end
                    end
                end

                COMMIT: begin
                    tag_we    <= 1'b0;
                    valid_set <= 1'b0;
                    tag_idx   <= '0;
                    tag_wdata <= '0;
                    state     <= DONE;
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_refill.sv
// tb/tb_cache_refill.sv - randomized self-checking bench for cache_refill
module tb_cache_refill;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic [31:0] addr;
    logic        miss_in;
    logic        stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        data_we;
    logic [4:0]  data_idx;
    logic [2:0]  data_word;
    logic [31:0] data_wdata;
    logic        tag_we;
    logic [4:0]  tag_idx;
    logic [21:0] tag_wdata;
    logic        valid_set;

    int n_checks = 0;
    int n_errors = 0;
    int tag_pulses = 0;
    int exp_tag_pulses = 0;

    cache_refill dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .addr       (addr),
        .miss_in    (miss_in),
        .stall      (stall),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .data_we    (data_we),
        .data_idx   (data_idx),
        .data_word  (data_word),
        .data_wdata (data_wdata),
        .tag_we     (tag_we),
        .tag_idx    (tag_idx),
        .tag_wdata  (tag_wdata),
        .valid_set  (valid_set)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tag_we === 1'b1) tag_pulses++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stall"},      32'(stall), 32'd0);
        check({tag, "_mem_req"},    32'(mem_req), 32'd0);
        check({tag, "_mem_addr"},   mem_addr, 32'd0);
        check({tag, "_data_we"},    32'(data_we), 32'd0);
        check({tag, "_data_idx"},   32'(data_idx), 32'd0);
        check({tag, "_data_word"},  32'(data_word), 32'd0);
        check({tag, "_data_wdata"}, data_wdata, 32'd0);
        check({tag, "_tag_we"},     32'(tag_we), 32'd0);
        check({tag, "_tag_idx"},    32'(tag_idx), 32'd0);
        check({tag, "_tag_wdata"},  32'(tag_wdata), 32'd0);
        check({tag, "_valid_set"},  32'(valid_set), 32'd0);
    endtask

    // Cycles with no miss request: nothing may start, stray acks write nothing.
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            cpu_req   = $urandom_range(0, 1);
            miss_in   = ~cpu_req;
            addr      = $urandom;
            mem_ack   = $urandom_range(0, 1);
            mem_rdata = $urandom;
            @(negedge clk);
            check("idle_stall",   32'(stall), 32'd0);
            check("idle_mem_req", 32'(mem_req), 32'd0);
            check("idle_data_we", 32'(data_we), 32'd0);
            check("idle_tag_we",  32'(tag_we), 32'd0);
        end
    endtask

    // One complete refill of the line holding a.
    // mode: 0 = ack every cycle, 1 = ack after 3 cycles, 2 = random 1..4 latency.
    // scramble drives addr=0 while busy; chain presents next_a as a miss in the
    // final (non-stalled) cycle, which must only be taken up the cycle after.
    task automatic refill(input logic [31:0] a, input int mode, input bit scramble,
                          input bit chain, input logic [31:0] next_a);
        int          lat;
        int          lat_sum;
        int          stall_cycles;
        logic [31:0] base;
        logic [31:0] rd;
        lat_sum      = 0;
        stall_cycles = 0;
        base         = {a[31:5], 5'b0};

        @(posedge clk); #1;
        cpu_req   = 1'b1;
        miss_in   = 1'b1;
        addr      = a;
        mem_ack   = $urandom_range(0, 1);
        mem_rdata = $urandom;
        @(negedge clk);
        stall_cycles += int'(stall);
        check("miss_stall",   32'(stall), 32'd1);
        check("miss_mem_req", 32'(mem_req), 32'd0);
        check("miss_data_we", 32'(data_we), 32'd0);

        for (int k = 0; k < 8; k++) begin
            lat = (mode == 0) ? 1 : (mode == 1) ? 3 : int'($urandom_range(1, 4));
            lat_sum += lat;
            for (int w = 1; w <= lat; w++) begin
                @(posedge clk); #1;
                cpu_req   = $urandom_range(0, 1);
                miss_in   = $urandom_range(0, 1);
                addr      = scramble ? 32'h0 : a;
                mem_ack   = (w == lat);
                rd        = $urandom;
                mem_rdata = rd;
                @(negedge clk);
                stall_cycles += int'(stall);
                check("fetch_mem_req",  32'(mem_req), 32'd1);
                check("fetch_mem_addr", mem_addr, base + 32'(4 * k));
                check("fetch_data_we",  32'(data_we), 32'(w == lat));
                check("fetch_tag_we",   32'(tag_we), 32'd0);
                if (w == lat) begin
                    check("fetch_data_idx",   32'(data_idx), 32'(a[9:5]));
                    check("fetch_data_word",  32'(data_word), 32'(k));
                    check("fetch_data_wdata", data_wdata, rd);
                end
            end
        end

        @(posedge clk); #1;
        cpu_req   = $urandom_range(0, 1);
        miss_in   = $urandom_range(0, 1);
        addr      = scramble ? 32'h0 : a;
        mem_ack   = $urandom_range(0, 1);
        mem_rdata = $urandom;
        @(negedge clk);
        stall_cycles += int'(stall);
        exp_tag_pulses++;
        check("commit_tag_we",    32'(tag_we), 32'd1);
        check("commit_valid_set", 32'(valid_set), 32'd1);
        check("commit_tag_idx",   32'(tag_idx), 32'(a[9:5]));
        check("commit_tag_wdata", 32'(tag_wdata), 32'(a[31:10]));
        check("commit_data_we",   32'(data_we), 32'd0);
        check("commit_mem_req",   32'(mem_req), 32'd0);

        @(posedge clk); #1;
        if (chain) begin
            cpu_req = 1'b1;
            miss_in = 1'b1;
            addr    = next_a;
        end else begin
            cpu_req = $urandom_range(0, 1);
            miss_in = $urandom_range(0, 1);
            addr    = $urandom;
        end
        mem_ack   = $urandom_range(0, 1);
        mem_rdata = $urandom;
        @(negedge clk);
        stall_cycles += int'(stall);
        check("done_stall",   32'(stall), 32'd0);
        check("done_tag_we",  32'(tag_we), 32'd0);
        check("done_data_we", 32'(data_we), 32'd0);
        check("done_mem_req", 32'(mem_req), 32'd0);
        check("stall_cycles", 32'(stall_cycles), 32'(lat_sum + 2));
    endtask

    // Refill interrupted by reset after five words have been written.
    task automatic reset_mid_refill(input logic [31:0] a);
        @(posedge clk); #1;
        cpu_req = 1'b1;
        miss_in = 1'b1;
        addr    = a;
        mem_ack = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            cpu_req   = 1'b0;
            miss_in   = 1'b0;
            mem_ack   = 1'b1;
            mem_rdata = $urandom;
            @(negedge clk);
            check("rstmid_mem_addr", mem_addr, {a[31:5], 5'b0} + 32'(4 * k));
        end
        @(posedge clk); #1;
        rst       = 1'b1;
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        @(negedge clk);
        check_all_zero("rstmid");
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] nxt;
        bit          chain;

        rst       = 1'b1;
        cpu_req   = 1'b0;
        miss_in   = 1'b0;
        addr      = 32'h0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Miss flag without a request must be ignored.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            cpu_req = 1'b0;
            miss_in = 1'b1;
            mem_ack = $urandom_range(0, 1);
            @(negedge clk);
            check("noreq_stall",   32'(stall), 32'd0);
            check("noreq_mem_req", 32'(mem_req), 32'd0);
        end

        refill(32'hFFFF_FC20, 0, 1'b0, 1'b0, 32'h0);
        idle_cycles(2);
        refill($urandom, 1, 1'b0, 1'b0, 32'h0);
        idle_cycles(2);
        refill(32'h1234_5678, 2, 1'b1, 1'b0, 32'h0);
        idle_cycles(1);

        reset_mid_refill(32'hABCD_E0E0);
        idle_cycles(2);
        refill(32'hABCD_E0E0, 0, 1'b0, 1'b0, 32'h0);

        refill(32'h0000_03E0, 0, 1'b0, 1'b1, 32'h8000_0040);
        refill(32'h8000_0040, 2, 1'b0, 1'b0, 32'h0);
        idle_cycles(1);

        a = $urandom;
        for (int i = 0; i < 12; i++) begin
            nxt   = $urandom;
            chain = 1'($urandom_range(0, 1));
            refill(a, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), chain, nxt);
            if (!chain) idle_cycles(int'($urandom_range(1, 3)));
            a = nxt;
        end

        idle_cycles(2);
        check("tag_we_total", 32'(tag_pulses), 32'(exp_tag_pulses));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
